// File: rtl/contrast_filter_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// contrast_filter_seq
//
// Row sequencer for the contrast pre-filter. One filter_begin pulse sweeps a
// full row-buffer line (ROW_LEN words), feeds the line back into the rotating
// row buffers after WB_DLY cycles, registers the TAPS pixel taps for the HLS
// filter core and captures OUT_PER_ROW consecutive filter results into the
// filter buffer. Capture starts once the read sweep reaches START_OFFSET.
//
// Optional feature macro: CONTRAST_FILTER_DROP_CNT_EN
//   defined   -> drop_cnt counts rows skipped because filbuf_wready was low
//                at the capture point (saturating at 255).
//   undefined -> drop_cnt is tied to 0. Skipped rows still complete normally.
//
// Ports:
//   s_axi_aclk       clock
//   s_axi_aresetn    asynchronous active-low reset
//   filter_begin     start one row (pulse, honoured only when idle)
//   frame_start      clear filbuf_wraddr/row_count/drop_cnt (honoured when idle)
//   filbuf_wready    filter buffer can accept a row (sampled at capture point)
//   rowbuf_rden      row buffer read enable
//   rowbuf_rdaddr    row buffer read address
//   rowbuf_wren      row buffer write-back enable (rden delayed by WB_DLY)
//   rowbuf_wraddr    row buffer write-back address (0 when wren is low)
//   rowbuf_rddata    tap data, tap k at [k*PIX_W +: PIX_W]
//   filter_ap_start  HLS core start (high for the whole row)
//   filter_d         registered taps to the filter core
//   filter_result    filter core output
//   filbuf_wren      filter buffer write enable
//   filbuf_wraddr    filter buffer write address (wraps modulo 2^FB_AW)
//   filbuf_wrdata    filter buffer write data (0 when wren is low)
//   busy             row in progress
//   row_done         one-cycle pulse when a row has fully drained
//   row_count        rows completed since frame_start (wraps at 2^16)
//   drop_cnt         rows skipped for lack of filbuf_wready
// -----------------------------------------------------------------------------
module contrast_filter_seq #(
   parameter int PIX_W        = 8,
   parameter int TAPS         = 17,
   parameter int ROW_LEN      = 144,
   parameter int OUT_PER_ROW  = 128,
   parameter int START_OFFSET = 26,
   parameter int RES_W        = 32,
   parameter int FB_AW        = 14,
   parameter int WB_DLY       = 2
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  filter_begin,
   input  logic                  frame_start,
   input  logic                  filbuf_wready,
   output logic                  rowbuf_rden,
   output logic [7:0]            rowbuf_rdaddr,
   output logic                  rowbuf_wren,
   output logic [7:0]            rowbuf_wraddr,
   input  logic [TAPS*PIX_W-1:0] rowbuf_rddata,
   output logic                  filter_ap_start,
   output logic [TAPS*PIX_W-1:0] filter_d,
   input  logic [RES_W-1:0]      filter_result,
   output logic                  filbuf_wren,
   output logic [FB_AW-1:0]      filbuf_wraddr,
   output logic [RES_W-1:0]      filbuf_wrdata,
   output logic                  busy,
   output logic                  row_done,
   output logic [15:0]           row_count,
   output logic [7:0]            drop_cnt
);

   // Remaining-write counter only ever holds OUT_PER_ROW-1 down to 0.
   localparam int CNT_W = (OUT_PER_ROW > 1) ? $clog2(OUT_PER_ROW) : 1;

   localparam logic [7:0]       LAST_ADDR  = 8'(ROW_LEN - 1);
   localparam logic [7:0]       START_ADDR = 8'(START_OFFSET);
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(OUT_PER_ROW - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e                    state_q;
   state_e                    state_d;

   logic                      rden_q;
   logic [7:0]                rdaddr_q;
   logic [WB_DLY-1:0]         wb_en_q;
   logic [WB_DLY-1:0][7:0]    wb_addr_q;
   logic [TAPS*PIX_W-1:0]     taps_q;
   logic                      fb_wren_q;
   logic [FB_AW-1:0]          fb_wraddr_q;
   logic [RES_W-1:0]          fb_wrdata_q;
   logic [CNT_W-1:0]          wr_left_q;
   logic                      row_done_q;
   logic [15:0]               row_count_q;

   // Single-cycle control strobes decoded by the FSM.
   logic                      start_row_s;
   logic                      end_read_s;
   logic                      finish_row_s;
   logic                      frame_clr_s;
   logic                      capture_s;
   logic                      pipe_empty_s;

   // The row is only finished once neither the write-back pipe nor the
   // filter-buffer burst has anything left in flight.
   assign pipe_empty_s = (wb_en_q == {WB_DLY{1'b0}}) && !fb_wren_q;

   // Capture point: the read sweep presents START_OFFSET this cycle.
   assign capture_s    = rden_q && (rdaddr_q == START_ADDR);

   // frame_start is honoured only between rows.
   assign frame_clr_s  = (state_q == ST_IDLE) && frame_start;

   // FSM state register.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state and row control strobes.
   always_comb begin
      state_d      = state_q;
      start_row_s  = 1'b0;
      end_read_s   = 1'b0;
      finish_row_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (filter_begin) begin
               state_d     = ST_READ;
               start_row_s = 1'b1;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_READ: begin
            if (rdaddr_q == LAST_ADDR) begin
               state_d    = ST_DRAIN;
               end_read_s = 1'b1;
            end else begin
               state_d    = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (pipe_empty_s) begin
               state_d      = ST_IDLE;
               finish_row_s = 1'b1;
            end else begin
               state_d      = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Read sweep: address 0 on the cycle after filter_begin, then +1 per cycle.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         rden_q   <= 1'b0;
         rdaddr_q <= 8'd0;
      end else if (start_row_s) begin
         rden_q   <= 1'b1;
         rdaddr_q <= 8'd0;
      end else if (end_read_s) begin
         rden_q   <= 1'b0;
         rdaddr_q <= 8'd0;
      end else if (rden_q) begin
         rdaddr_q <= rdaddr_q + 8'd1;
      end else begin
         rdaddr_q <= 8'd0;
      end
   end

   // Write-back shift pipe: rden/rdaddr delayed by WB_DLY cycles.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         wb_en_q   <= {WB_DLY{1'b0}};
         wb_addr_q <= '{default: 8'd0};
      end else begin
         wb_en_q[0]   <= rden_q;
         wb_addr_q[0] <= rden_q ? rdaddr_q : 8'd0;
         for (int i = 1; i < WB_DLY; i++) begin
            wb_en_q[i]   <= wb_en_q[i-1];
            wb_addr_q[i] <= wb_addr_q[i-1];
         end
      end
   end

   // Tap register: unconditional one-cycle copy of the row buffer output.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         taps_q <= {(TAPS*PIX_W){1'b0}};
      end else begin
         taps_q <= rowbuf_rddata;
      end
   end

   // Filter-buffer burst: OUT_PER_ROW consecutive writes after the capture
   // point; data is the filter result registered at each edge of the burst.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         fb_wren_q   <= 1'b0;
         fb_wrdata_q <= {RES_W{1'b0}};
         wr_left_q   <= {CNT_W{1'b0}};
      end else if (capture_s && filbuf_wready) begin
         fb_wren_q   <= 1'b1;
         fb_wrdata_q <= filter_result;
         wr_left_q   <= CNT_LOAD;
      end else if (fb_wren_q && (wr_left_q != {CNT_W{1'b0}})) begin
         fb_wren_q   <= 1'b1;
         fb_wrdata_q <= filter_result;
         wr_left_q   <= wr_left_q - CNT_W'(1);
      end else begin
         fb_wren_q   <= 1'b0;
         fb_wrdata_q <= {RES_W{1'b0}};
         wr_left_q   <= {CNT_W{1'b0}};
      end
   end

   // Filter-buffer address: advances after every write, cleared by frame_start.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         fb_wraddr_q <= {FB_AW{1'b0}};
      end else if (frame_clr_s) begin
         fb_wraddr_q <= {FB_AW{1'b0}};
      end else if (fb_wren_q) begin
         fb_wraddr_q <= fb_wraddr_q + FB_AW'(1);
      end else begin
         fb_wraddr_q <= fb_wraddr_q;
      end
   end

   // Row completion pulse and completed-row counter.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         row_done_q  <= 1'b0;
         row_count_q <= 16'd0;
      end else begin
         row_done_q <= finish_row_s;
         if (frame_clr_s) begin
            row_count_q <= 16'd0;
         end else if (finish_row_s) begin
            row_count_q <= row_count_q + 16'd1;
         end else begin
            row_count_q <= row_count_q;
         end
      end
   end

`ifdef CONTRAST_FILTER_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   // Skipped-row counter, saturating so it never wraps back to a small value.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         drop_cnt_q <= 8'd0;
      end else if (frame_clr_s) begin
         drop_cnt_q <= 8'd0;
      end else if (capture_s && !filbuf_wready && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end else begin
         drop_cnt_q <= drop_cnt_q;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'd0;
`endif

   // Outputs come straight from registers.
   assign busy            = (state_q != ST_IDLE);
   assign filter_ap_start = (state_q != ST_IDLE);
   assign rowbuf_rden     = rden_q;
   assign rowbuf_rdaddr   = rdaddr_q;
   assign rowbuf_wren     = wb_en_q[WB_DLY-1];
   assign rowbuf_wraddr   = wb_addr_q[WB_DLY-1];
   assign filter_d        = taps_q;
   assign filbuf_wren     = fb_wren_q;
   assign filbuf_wraddr   = fb_wraddr_q;
   assign filbuf_wrdata   = fb_wrdata_q;
   assign row_done        = row_done_q;
   assign row_count       = row_count_q;

endmodule

// File: tb/tb_contrast_filter_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for contrast_filter_seq (default parameters).
// filter_result is a free-running edge counter, so the value captured at an
// edge equals that edge's index; expected burst data follow from the edge at
// which filter_begin was sampled plus START_OFFSET+1.
module tb_contrast_filter_seq;

   localparam int PIX_W       = 8;
   localparam int TAPS        = 17;
   localparam int ROW_LEN     = 144;
   localparam int OUT_PER_ROW = 128;
   localparam int RES_W       = 32;
   localparam int FB_AW       = 14;
   localparam int CAP_LAT     = 27;     // begin edge -> capture edge
   localparam int FB_MOD      = 16384;
   localparam int CW          = TAPS*PIX_W;

`ifdef CONTRAST_FILTER_DROP_CNT_EN
   localparam int DROP_ON = 1;
`else
   localparam int DROP_ON = 0;
`endif

   typedef logic [CW-1:0] cv_t;
   typedef struct packed {
      logic [FB_AW-1:0] addr;
      logic [RES_W-1:0] data;
   } fb_exp_t;

   logic              s_axi_aclk = 1'b0;
   logic              s_axi_aresetn;
   logic              filter_begin;
   logic              frame_start;
   logic              filbuf_wready;
   logic              rowbuf_rden;
   logic [7:0]        rowbuf_rdaddr;
   logic              rowbuf_wren;
   logic [7:0]        rowbuf_wraddr;
   logic [CW-1:0]     rowbuf_rddata;
   logic              filter_ap_start;
   logic [CW-1:0]     filter_d;
   logic [RES_W-1:0]  filter_result;
   logic              filbuf_wren;
   logic [FB_AW-1:0]  filbuf_wraddr;
   logic [RES_W-1:0]  filbuf_wrdata;
   logic              busy;
   logic              row_done;
   logic [15:0]       row_count;
   logic [7:0]        drop_cnt;

   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          rd_cnt = 0, wb_cnt = 0, fbw_cnt = 0, done_cnt = 0;
   int          exp_fb_addr = 0;
   fb_exp_t     fb_q[$];
   int          rd_q[$];
   fb_exp_t     mon_e;
   logic        h_en0 = 1'b0, h_en1 = 1'b0;
   logic [7:0]  h_ad0 = 8'd0, h_ad1 = 8'd0;

   always #5 s_axi_aclk = ~s_axi_aclk;

   always @(posedge s_axi_aclk) cyc <= cyc + 1;

   function automatic logic [CW-1:0] tapgen(input int unsigned c);
      logic [CW-1:0] v;
      for (int k = 0; k < TAPS; k++) v[k*PIX_W +: PIX_W] = PIX_W'(c*3 + k*17);
      return v;
   endfunction

   assign rowbuf_rddata = tapgen(cyc);
   assign filter_result = cyc;

   contrast_filter_seq dut (
      .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
      .filter_begin(filter_begin), .frame_start(frame_start),
      .filbuf_wready(filbuf_wready),
      .rowbuf_rden(rowbuf_rden), .rowbuf_rdaddr(rowbuf_rdaddr),
      .rowbuf_wren(rowbuf_wren), .rowbuf_wraddr(rowbuf_wraddr),
      .rowbuf_rddata(rowbuf_rddata),
      .filter_ap_start(filter_ap_start), .filter_d(filter_d),
      .filter_result(filter_result),
      .filbuf_wren(filbuf_wren), .filbuf_wraddr(filbuf_wraddr),
      .filbuf_wrdata(filbuf_wrdata),
      .busy(busy), .row_done(row_done), .row_count(row_count),
      .drop_cnt(drop_cnt)
   );

   task automatic check(input string name, input cv_t act, input cv_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a transfer.
   always @(negedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         h_en0 = 1'b0; h_en1 = 1'b0; h_ad0 = 8'd0; h_ad1 = 8'd0;
      end else begin
         if (filbuf_wren) begin
            fbw_cnt++;
            if (fb_q.size() == 0) begin
               check("fb_unexpected_write", cv_t'(filbuf_wraddr), cv_t'(0));
            end else begin
               mon_e = fb_q.pop_front();
               check("fb_addr", cv_t'(filbuf_wraddr), cv_t'(mon_e.addr));
               check("fb_data", cv_t'(filbuf_wrdata), cv_t'(mon_e.data));
            end
         end else begin
            check("fb_data_idle", cv_t'(filbuf_wrdata), cv_t'(0));
         end
         if (rowbuf_rden) begin
            rd_cnt++;
            if (rd_q.size() == 0)
               check("rd_unexpected", cv_t'(rowbuf_rdaddr), cv_t'(9'h100));
            else
               check("rd_addr", cv_t'(rowbuf_rdaddr), cv_t'(rd_q.pop_front()));
         end
         if (rowbuf_wren || h_en1) begin
            check("wb_en", cv_t'(rowbuf_wren), cv_t'(h_en1));
            check("wb_addr", cv_t'(rowbuf_wraddr), cv_t'(h_ad1));
         end
         if (rowbuf_wren) wb_cnt++;
         if (row_done) done_cnt++;
         h_en1 = h_en0; h_ad1 = h_ad0;
         h_en0 = rowbuf_rden; h_ad0 = rowbuf_rdaddr;
      end
   end

   // Called at a negedge; pulses filter_begin for one edge and queues the row.
   task automatic start_row(input bit expect_wr, input bit with_frame);
      int unsigned e0;
      fb_exp_t ex;
      e0 = cyc;
      if (with_frame) begin
         frame_start = 1'b1;
         exp_fb_addr = 0;
      end
      filter_begin = 1'b1;
      for (int i = 0; i < ROW_LEN; i++) rd_q.push_back(i);
      if (expect_wr) begin
         for (int i = 0; i < OUT_PER_ROW; i++) begin
            ex.addr = FB_AW'((exp_fb_addr + i) % FB_MOD);
            ex.data = RES_W'(e0 + CAP_LAT + i);
            fb_q.push_back(ex);
         end
         exp_fb_addr = (exp_fb_addr + OUT_PER_ROW) % FB_MOD;
      end
      @(negedge s_axi_aclk);
      filter_begin = 1'b0;
      frame_start  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge s_axi_aclk);
         if (row_done) seen = 1'b1;
      end
      check({name, "_row_done"}, cv_t'(seen), cv_t'(1));
      @(negedge s_axi_aclk);
   endtask

   task automatic wait_rdaddr(input logic [7:0] a, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (rowbuf_rden && rowbuf_rdaddr == a) seen = 1'b1;
         else @(negedge s_axi_aclk);
      end
      check({name, "_reach_rdaddr"}, cv_t'(seen), cv_t'(1));
   endtask

   task automatic check_all_zero(input string t);
      check({t, "_rden"},   cv_t'(rowbuf_rden), cv_t'(0));
      check({t, "_rdaddr"}, cv_t'(rowbuf_rdaddr), cv_t'(0));
      check({t, "_wren"},   cv_t'(rowbuf_wren), cv_t'(0));
      check({t, "_wraddr"}, cv_t'(rowbuf_wraddr), cv_t'(0));
      check({t, "_start"},  cv_t'(filter_ap_start), cv_t'(0));
      check({t, "_taps"},   filter_d, cv_t'(0));
      check({t, "_fbwren"}, cv_t'(filbuf_wren), cv_t'(0));
      check({t, "_fbaddr"}, cv_t'(filbuf_wraddr), cv_t'(0));
      check({t, "_fbdata"}, cv_t'(filbuf_wrdata), cv_t'(0));
      check({t, "_busy"},   cv_t'(busy), cv_t'(0));
      check({t, "_done"},   cv_t'(row_done), cv_t'(0));
      check({t, "_rowcnt"}, cv_t'(row_count), cv_t'(0));
      check({t, "_drop"},   cv_t'(drop_cnt), cv_t'(0));
   endtask

   initial begin
      int rd0, wb0, fb0, dn0;
      s_axi_aresetn = 1'b1;
      filter_begin  = 1'b0;
      frame_start   = 1'b0;
      filbuf_wready = 1'b1;
      #1 s_axi_aresetn = 1'b0;
      repeat (3) @(negedge s_axi_aclk);
      check_all_zero("reset");
      #2 s_axi_aresetn = 1'b1;
      repeat (2) @(negedge s_axi_aclk);

      // Row 1: basic sweep, write-back and 128-result burst.
      rd0 = rd_cnt; wb0 = wb_cnt; fb0 = fbw_cnt; dn0 = done_cnt;
      start_row(1'b1, 1'b0);
      check("r1_first_rden",   cv_t'(rowbuf_rden), cv_t'(1));
      check("r1_first_rdaddr", cv_t'(rowbuf_rdaddr), cv_t'(0));
      check("r1_busy",         cv_t'(busy), cv_t'(1));
      check("r1_ap_start",     cv_t'(filter_ap_start), cv_t'(1));
      check("r1_taps",         filter_d, tapgen(cyc - 1));
      wait_done("r1");
      check("r1_done_once",  cv_t'(done_cnt - dn0), cv_t'(1));
      check("r1_done_pulse", cv_t'(row_done), cv_t'(0));
      check("r1_idle",       cv_t'(busy), cv_t'(0));
      check("r1_rows",       cv_t'(row_count), cv_t'(1));
      check("r1_fbaddr",     cv_t'(filbuf_wraddr), cv_t'(128));
      check("r1_rd_cnt",     cv_t'(rd_cnt - rd0), cv_t'(144));
      check("r1_wb_cnt",     cv_t'(wb_cnt - wb0), cv_t'(144));
      check("r1_fb_cnt",     cv_t'(fbw_cnt - fb0), cv_t'(128));
      check("r1_queue_empty", cv_t'(fb_q.size()), cv_t'(0));

      // Row 2: begin one cycle after row_done, address continues at 128.
      start_row(1'b1, 1'b0);
      wait_done("r2");
      check("r2_rows",   cv_t'(row_count), cv_t'(2));
      check("r2_fbaddr", cv_t'(filbuf_wraddr), cv_t'(256));

      // Row 3: filter buffer not ready at the capture point.
      filbuf_wready = 1'b0;
      fb0 = fbw_cnt; dn0 = done_cnt;
      start_row(1'b0, 1'b0);
      wait_done("r3");
      filbuf_wready = 1'b1;
      check("r3_no_writes", cv_t'(fbw_cnt - fb0), cv_t'(0));
      check("r3_done_once", cv_t'(done_cnt - dn0), cv_t'(1));
      check("r3_fbaddr",    cv_t'(filbuf_wraddr), cv_t'(256));
      check("r3_drop",      cv_t'(drop_cnt), cv_t'(DROP_ON));
      check("r3_rows",      cv_t'(row_count), cv_t'(3));

      // Row 4: second filter_begin mid-row is ignored.
      rd0 = rd_cnt; dn0 = done_cnt;
      start_row(1'b1, 1'b0);
      wait_rdaddr(8'd50, "r4");
      filter_begin = 1'b1;
      @(negedge s_axi_aclk);
      filter_begin = 1'b0;
      wait_done("r4");
      repeat (10) @(negedge s_axi_aclk);
      check("r4_single_sweep", cv_t'(rd_cnt - rd0), cv_t'(144));
      check("r4_done_once",    cv_t'(done_cnt - dn0), cv_t'(1));
      check("r4_idle",         cv_t'(busy), cv_t'(0));
      check("r4_fbaddr",       cv_t'(filbuf_wraddr), cv_t'(384));

      // Rows 5..129: walk the address to the 2^14 wrap point.
      for (int r = 0; r < 125; r++) begin
         start_row(1'b1, 1'b0);
         wait_done("wrap_row");
      end
      check("wrap_fbaddr", cv_t'(filbuf_wraddr), cv_t'(0));
      check("wrap_rows",   cv_t'(row_count), cv_t'(129));
      start_row(1'b1, 1'b0);
      wait_done("post_wrap");
      check("post_wrap_fbaddr", cv_t'(filbuf_wraddr), cv_t'(128));

      // frame_start alone in IDLE clears the counters.
      frame_start = 1'b1;
      exp_fb_addr = 0;
      @(negedge s_axi_aclk);
      frame_start = 1'b0;
      @(negedge s_axi_aclk);
      check("frame_fbaddr", cv_t'(filbuf_wraddr), cv_t'(0));
      check("frame_rows",   cv_t'(row_count), cv_t'(0));
      check("frame_drop",   cv_t'(drop_cnt), cv_t'(0));

      // frame_start coincident with filter_begin, then ignored mid-row.
      start_row(1'b1, 1'b0);
      wait_done("pre_coinc");
      start_row(1'b1, 1'b1);
      wait_rdaddr(8'd100, "coinc");
      frame_start = 1'b1;
      @(negedge s_axi_aclk);
      frame_start = 1'b0;
      wait_done("coinc");
      check("coinc_fbaddr", cv_t'(filbuf_wraddr), cv_t'(128));
      check("coinc_rows",   cv_t'(row_count), cv_t'(1));

      // Reset in the middle of a row.
      start_row(1'b1, 1'b0);
      wait_rdaddr(8'd70, "rst");
      #2 s_axi_aresetn = 1'b0;
      #1 check_all_zero("midrow_rst");
      rd_q.delete();
      fb_q.delete();
      exp_fb_addr = 0;
      dn0 = done_cnt;
      repeat (3) @(negedge s_axi_aclk);
      #2 s_axi_aresetn = 1'b1;
      repeat (2) @(negedge s_axi_aclk);
      check("rst_no_done", cv_t'(done_cnt - dn0), cv_t'(0));
      check("rst_idle",    cv_t'(busy), cv_t'(0));
      rd0 = rd_cnt;
      start_row(1'b1, 1'b0);
      check("clean_rdaddr", cv_t'(rowbuf_rdaddr), cv_t'(0));
      check("clean_rden",   cv_t'(rowbuf_rden), cv_t'(1));
      wait_done("clean");
      check("clean_rows",   cv_t'(row_count), cv_t'(1));
      check("clean_fbaddr", cv_t'(filbuf_wraddr), cv_t'(128));
      check("clean_rd_cnt", cv_t'(rd_cnt - rd0), cv_t'(144));
      check("clean_queue",  cv_t'(fb_q.size() + rd_q.size()), cv_t'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
